aes_job_sched: RTL and testbench

Scheduler that shares one iterative AES-128 engine (key expander plus round core) between two requesters. It arbitrates round-robin, loads the round keys only when the job key differs from the cached key, and sequences the start/done handshakes of the expander and the core. It returns each result tagged with the requester ID. It sits between the requester-side logic and the AES datapath, in place of direct top-level wiring of key and plaintext.

---
 rtl/aes_job_sched_pkg.sv | 23 ++
 rtl/aes_job_sched_if.sv | 41 ++++
 rtl/aes_job_sched_arb.sv | 17 +
 rtl/aes_job_sched.sv | 167 ++++++++++++++++
 tb/tb_aes_job_sched.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_job_sched_pkg.sv
// Shared types and constants for the two-requester AES job scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_BLK_W       = 128;
  localparam int unsigned NREQ            = 2;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t S_IDLE   = 2'd0;
  localparam sched_state_t S_KEYEXP = 2'd1;
  localparam sched_state_t S_RUN    = 2'd2;
  localparam sched_state_t S_RESP   = 2'd3;

  // Accepted job as latched at the grant.
  typedef struct packed {
    logic                 id;
    logic                 decrypt;
    logic [AES_BLK_W-1:0] key;
    logic [AES_BLK_W-1:0] data;
  } sched_job_t;

endpackage

// File: rtl/aes_job_sched_if.sv
// Requester, response and AES datapath signals of the job scheduler.
interface aes_job_sched_if;
  import aes_sched_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           req_decrypt;
  logic [NREQ*AES_BLK_W-1:0] req_key;
  logic [NREQ*AES_BLK_W-1:0] req_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic                      rsp_err;
  logic [AES_BLK_W-1:0]      rsp_data;
  logic                      kexp_start;
  logic [AES_BLK_W-1:0]      kexp_key;
  logic                      kexp_done;
  logic                      core_start;
  logic                      core_decrypt;
  logic [AES_BLK_W-1:0]      core_data;
  logic                      core_done;
  logic [AES_BLK_W-1:0]      core_result;
  logic                      busy;

  // Environment side: requesters, response consumer and the AES datapath.
  modport master (
    output req_valid, req_decrypt, req_key, req_data, rsp_ready,
           kexp_done, core_done, core_result,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
           kexp_start, kexp_key, core_start, core_decrypt, core_data, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_decrypt, req_key, req_data, rsp_ready,
           kexp_done, core_done, core_result,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
           kexp_start, kexp_key, core_start, core_decrypt, core_data, busy
  );

endinterface

// File: rtl/aes_job_sched_arb.sv
// Combinational two-way round-robin grant; the pointer lives in the parent.
module aes_rr_arb2 (
  input  logic       en,
  input  logic       rr_ptr,
  input  logic [1:0] valid,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (valid[rr_ptr])       grant_c[rr_ptr]  = 1'b1;
      else if (valid[~rr_ptr]) grant_c[~rr_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/aes_job_sched.sv
// Shares one iterative AES-128 engine between two requesters, skipping key
// expansion when the job key matches the cached key.
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  aes_job_sched_if.slave bus
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t         state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 key_cached_q, key_cached_d;
  logic [AES_BLK_W-1:0] cache_key_q, cache_key_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  sched_job_t           job_q, job_d;
  logic                 kexp_start_q, kexp_start_d;
  logic                 core_start_q, core_start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [AES_BLK_W-1:0] rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;

  logic [1:0]           grant;
  logic                 accept;
  logic                 sel;
  logic [AES_BLK_W-1:0] sel_key;
  logic [AES_BLK_W-1:0] sel_data;

  aes_rr_arb2 u_arb (
    .en      (state_q == S_IDLE),
    .rr_ptr  (rr_ptr_q),
    .valid   (bus.req_valid),
    .grant_c (grant)
  );

  assign accept   = |(bus.req_valid & grant);
  assign sel      = grant[1];
  assign sel_key  = sel ? bus.req_key[2*AES_BLK_W-1 -: AES_BLK_W]
                        : bus.req_key[AES_BLK_W-1:0];
  assign sel_data = sel ? bus.req_data[2*AES_BLK_W-1 -: AES_BLK_W]
                        : bus.req_data[AES_BLK_W-1:0];

  // Next-state and registered-output logic; a done pulse beats a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    key_cached_d = key_cached_q;
    cache_key_d  = cache_key_q;
    cnt_d        = '0;
    job_d        = job_q;
    kexp_start_d = 1'b0;
    core_start_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          job_d.id      = sel;
          job_d.decrypt = bus.req_decrypt[sel];
          job_d.key     = sel_key;
          job_d.data    = sel_data;
          rr_ptr_d      = ~sel;
          if (key_cached_q && (sel_key == cache_key_q)) begin
            state_d      = S_RUN;
            core_start_d = 1'b1;
          end else begin
            state_d      = S_KEYEXP;
            kexp_start_d = 1'b1;
            key_cached_d = 1'b0;
          end
        end
      end
      S_KEYEXP: begin
        if (bus.kexp_done) begin
          cache_key_d  = job_q.key;
          key_cached_d = 1'b1;
          core_start_d = 1'b1;
          state_d      = S_RUN;
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d    = 1'b1;
          rsp_data_d   = '0;
          rsp_valid_d  = 1'b1;
          key_cached_d = 1'b0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (bus.core_done) begin
          rsp_data_d  = bus.core_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d    = 1'b1;
          rsp_data_d   = '0;
          rsp_valid_d  = 1'b1;
          key_cached_d = 1'b0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= 1'b0;
      key_cached_q <= 1'b0;
      cache_key_q  <= '0;
      cnt_q        <= '0;
      job_q        <= '0;
      kexp_start_q <= 1'b0;
      core_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      key_cached_q <= key_cached_d;
      cache_key_q  <= cache_key_d;
      cnt_q        <= cnt_d;
      job_q        <= job_d;
      kexp_start_q <= kexp_start_d;
      core_start_q <= core_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = job_q.id;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.kexp_start   = kexp_start_q;
  assign bus.kexp_key     = job_q.key;
  assign bus.core_start   = core_start_q;
  assign bus.core_decrypt = job_q.decrypt;
  assign bus.core_data    = job_q.data;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed self-checking bench for aes_job_sched (timeout shortened to 16).
module tb_aes_job_sched;

  localparam logic [127:0] K0 = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] D0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D1 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] R0 = 128'hA5A5A5A5_11111111_22222222_33333333;
  localparam logic [127:0] R1 = 128'h5A5A5A5A_44444444_55555555_66666666;
  localparam logic [127:0] R2 = 128'hDEADBEEF_00000000_CAFEF00D_00000010;
  localparam logic [127:0] R4 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] R5 = 128'h77777777_88888888_99999999_AAAAAAAA;
  localparam logic [127:0] R6 = 128'hBBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE;
  localparam logic [127:0] R7 = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  aes_job_sched_if bus ();

  aes_job_sched #(.TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_finish(input logic [127:0] res);
    bus.core_result = res;
    bus.core_done   = 1'b1;
    tick();
    bus.core_done   = 1'b0;
  endtask

  task automatic take_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 128'(bus.rsp_valid), 128'(0));
    chk({tag, "_idle"},     128'(bus.busy),      128'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 128'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                             bus.kexp_start, bus.core_start, bus.core_decrypt, bus.busy}),
        128'(0));
    chk({tag, "_rsp_data"},  bus.rsp_data,  128'(0));
    chk({tag, "_kexp_key"},  bus.kexp_key,  128'(0));
    chk({tag, "_core_data"}, bus.core_data, 128'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req_valid   = '0;
    bus.req_decrypt = '0;
    bus.req_key     = {K0, K0};
    bus.req_data    = {D1, D0};
    bus.rsp_ready   = 1'b0;
    bus.kexp_done   = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_all_zero("reset");

    // Job 1: requester 0 encrypt, cold cache.
    bus.req_valid = 2'b01;
    #1 chk("t1_grant", 128'(bus.req_ready), 128'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    chk("t1_kexp_start", 128'(bus.kexp_start), 128'(1));
    chk("t1_kexp_key",   bus.kexp_key,         K0);
    chk("t1_core_start", 128'(bus.core_start), 128'(0));
    chk("t1_busy",       128'(bus.busy),       128'(1));
    tick();
    chk("t1_kexp_pulse", 128'(bus.kexp_start), 128'(0));
    bus.kexp_done = 1'b1;
    tick();
    bus.kexp_done = 1'b0;
    chk("t1_core_start", 128'(bus.core_start),   128'(1));
    chk("t1_core_data",  bus.core_data,          D0);
    chk("t1_core_dec",   128'(bus.core_decrypt), 128'(0));
    tick();
    chk("t1_core_pulse", 128'(bus.core_start), 128'(0));
    core_finish(R0);
    chk("t1_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    chk("t1_rsp_id",    128'(bus.rsp_id),    128'(0));
    chk("t1_rsp_err",   128'(bus.rsp_err),   128'(0));
    chk("t1_rsp_data",  bus.rsp_data,        R0);
    take_rsp("t1");

    // Job 2: requester 1 decrypt, same key -> cache hit, minimum latency.
    bus.req_valid   = 2'b10;
    bus.req_decrypt = 2'b10;
    #1 chk("t2_grant", 128'(bus.req_ready), 128'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    chk("t2_no_kexp",    128'(bus.kexp_start),   128'(0));
    chk("t2_core_start", 128'(bus.core_start),   128'(1));
    chk("t2_core_dec",   128'(bus.core_decrypt), 128'(1));
    chk("t2_core_data",  bus.core_data,          D1);
    core_finish(R1);
    chk("t2_rsp_valid", 128'(bus.rsp_valid), 128'(1));
    chk("t2_rsp_id",    128'(bus.rsp_id),    128'(1));
    chk("t2_rsp_data",  bus.rsp_data,        R1);
    take_rsp("t2");

    // Both requesters valid for four jobs: grants alternate 0,1,0,1.
    bus.req_decrypt = 2'b00;
    for (int j = 0; j < 4; j++) begin
      bus.req_valid = 2'b11;
      #1 chk("t3_grant", 128'(bus.req_ready), (j % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
      tick();
      chk("t3_core_start", 128'(bus.core_start), 128'(1));
      chk("t3_ready_low",  128'(bus.req_ready),  128'(0));
      core_finish(R2 ^ 128'(j));
      chk("t3_rsp_id",   128'(bus.rsp_id),  128'(j % 2));
      chk("t3_rsp_data", bus.rsp_data,      R2 ^ 128'(j));
      chk("t3_ready_rsp", 128'(bus.req_ready), 128'(0));
      take_rsp("t3");
    end

    // Consumer stall for 10 cycles with both requesters still pending.
    #1 chk("t4_grant", 128'(bus.req_ready), 128'(2'b01));
    tick();
    core_finish(R4);
    for (int j = 0; j < 10; j++) begin
      chk("t4_stall_valid", 128'(bus.rsp_valid), 128'(1));
      chk("t4_stall_data",  bus.rsp_data,        R4);
      chk("t4_stall_ready", 128'(bus.req_ready), 128'(0));
      tick();
    end
    bus.req_valid = 2'b00;
    take_rsp("t4");

    // Timeout in RUN; requester 0 granted by fallback while pointer prefers 1.
    bus.req_valid = 2'b01;
    #1 chk("t5_grant", 128'(bus.req_ready), 128'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    chk("t5_core_start", 128'(bus.core_start), 128'(1));
    repeat (15) tick();
    chk("t5_before_to", 128'(bus.rsp_valid), 128'(0));
    tick();
    chk("t5_to_valid", 128'(bus.rsp_valid), 128'(1));
    chk("t5_to_err",   128'(bus.rsp_err),   128'(1));
    chk("t5_to_data",  bus.rsp_data,        128'(0));
    chk("t5_to_id",    128'(bus.rsp_id),    128'(0));
    take_rsp("t5");

    // Same key after a timeout re-expands; kexp_done on the timeout cycle wins.
    bus.req_valid = 2'b10;
    #1 chk("t5b_grant", 128'(bus.req_ready), 128'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    chk("t5b_kexp_start", 128'(bus.kexp_start), 128'(1));
    chk("t5b_core_start", 128'(bus.core_start), 128'(0));
    repeat (15) tick();
    chk("t5b_waiting", 128'({bus.core_start, bus.rsp_valid}), 128'(0));
    bus.kexp_done = 1'b1;
    tick();
    bus.kexp_done = 1'b0;
    chk("t5b_done_wins", 128'(bus.core_start), 128'(1));
    chk("t5b_no_rsp",    128'(bus.rsp_valid),  128'(0));
    core_finish(R5);
    chk("t5b_rsp_err",  128'(bus.rsp_err), 128'(0));
    chk("t5b_rsp_id",   128'(bus.rsp_id),  128'(1));
    chk("t5b_rsp_data", bus.rsp_data,      R5);
    take_rsp("t5b");

    // Stray done pulses in IDLE are ignored.
    bus.core_done = 1'b1;
    bus.kexp_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    bus.kexp_done = 1'b0;
    chk("stray_ctl", 128'({bus.rsp_valid, bus.core_start, bus.busy}), 128'(0));

    // Reset in RUN, then a late core_done.
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("t6_hit_run", 128'(bus.core_start), 128'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_finish(R6);
    chk_all_zero("t6_after_rst");
    bus.req_valid = 2'b01;
    #1 chk("t6_grant", 128'(bus.req_ready), 128'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    chk("t6_reexpand", 128'(bus.kexp_start), 128'(1));
    bus.kexp_done = 1'b1;
    tick();
    bus.kexp_done = 1'b0;
    chk("t6_core_start", 128'(bus.core_start), 128'(1));
    core_finish(R7);
    chk("t6_rsp_data", bus.rsp_data, R7);
    take_rsp("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
